// File: rtl/ddr_app_sequencer.sv
// ddr_app_sequencer
// Splits single/multi-beat CPU-side requests into per-beat MIG 7-series
// app_* commands with incrementing addresses, forwards write data under
// app_wdf_rdy flow control and buffers returned read data in a FWFT FIFO.
// Read commands are only issued when a FIFO slot is guaranteed, so MIG read
// data (which cannot be back-pressured) is never dropped in normal use.
// Ports:
//   i_clk, i_rst_n            ui_clk and async active-low reset
//   i_init_calib_complete     gates acceptance of new requests
//   i_req_* / o_req_ready     request channel (addr, len = beats-1, dir)
//   i_wdata* / o_wdata_ready  write-beat channel
//   o_rdata* / i_rdata_ready  read-beat channel (FIFO output)
//   o_app_* / i_app_*         MIG user interface
//   o_busy, o_rd_overflow     status
module ddr_app_sequencer #(
    parameter int ADDR_WIDTH    = 28,
    parameter int DATA_WIDTH    = 128,
    parameter int MASK_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_STEP     = 8,
    parameter int LEN_WIDTH     = 2,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_init_calib_complete,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_req_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [MASK_WIDTH-1:0] i_wbe,
    output logic                  o_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]            o_app_cmd,
    output logic                  o_app_en,
    input  logic                  i_app_rdy,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    input  logic                  i_app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] i_app_rd_data,
    input  logic                  i_app_rd_data_valid,
    output logic                  o_busy,
    output logic                  o_rd_overflow
);

    localparam int CNT_W = LEN_WIDTH + 1;
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int FC_W  = PTR_W + 1;
    localparam logic [FC_W-1:0]       DEPTH_C = FC_W'(RD_FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [2:0]            CMD_WR  = 3'b000;
    localparam logic [2:0]            CMD_RD  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                 state_r, state_nx;
    logic                   ready_en_r;
    logic [LEN_WIDTH-1:0]   len_r, len_nx;
    logic [CNT_W-1:0]       cmd_cnt_r, cmd_cnt_nx;
    logic [CNT_W-1:0]       dat_cnt_r, dat_cnt_nx;
    logic                   app_en_r, app_en_nx;
    logic [2:0]             app_cmd_r, app_cmd_nx;
    logic [ADDR_WIDTH-1:0]  app_addr_r, app_addr_nx;
    logic [FC_W-1:0]        outstanding_r, outstanding_nx;
    logic [FC_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic                   overflow_r;
    logic [DATA_WIDTH-1:0]  mem_r [RD_FIFO_DEPTH];

    logic [CNT_W-1:0]       last_s, beats_s;
    logic                   accept_s, cmd_hs_s, rd_hs_s, ret_s;
    logic                   dat_open_s, wdf_hs_s;
    logic [FC_W-1:0]        fifo_count_s, fifo_nx_s;
    logic                   fifo_full_s, push_s, pop_s, credit_s;

    // Counter compare values: last_s is the index of the final beat.
    assign last_s  = {1'b0, len_r};
    assign beats_s = last_s + {{(CNT_W-1){1'b0}}, 1'b1};

    // ready_en_r keeps o_req_ready low throughout reset.
    assign o_req_ready = ready_en_r & (state_r == ST_IDLE) & i_init_calib_complete;
    assign accept_s    = i_req_valid & o_req_ready;
    assign cmd_hs_s    = app_en_r & i_app_rdy;
    assign rd_hs_s     = cmd_hs_s & (app_cmd_r == CMD_RD);

    // Write data path: combinational pass-through, one beat per BL8 burst.
    assign dat_open_s     = (state_r == ST_WRITE) & (dat_cnt_r <= last_s);
    assign o_app_wdf_wren = i_wdata_valid & dat_open_s;
    assign o_wdata_ready  = i_app_wdf_rdy & dat_open_s;
    assign wdf_hs_s       = o_app_wdf_wren & i_app_wdf_rdy;
    assign o_app_wdf_data = i_wdata;
    assign o_app_wdf_mask = ~i_wbe;
    assign o_app_wdf_end  = o_app_wdf_wren;

    // Read-return FIFO (first-word-fall-through).
    assign fifo_count_s  = wr_ptr_r - rd_ptr_r;
    assign fifo_full_s   = (fifo_count_s == DEPTH_C);
    assign push_s        = i_app_rd_data_valid & ~fifo_full_s;
    assign o_rdata_valid = (fifo_count_s != {FC_W{1'b0}});
    assign pop_s         = o_rdata_valid & i_rdata_ready;
    assign o_rdata       = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign ret_s         = i_app_rd_data_valid & (outstanding_r != {FC_W{1'b0}});
    assign fifo_nx_s     = fifo_count_s + {{(FC_W-1){1'b0}}, push_s}
                                        - {{(FC_W-1){1'b0}}, pop_s};

    // A further read may be offered only if every read already issued plus
    // the new one still fits in the FIFO as of the next cycle.
    assign credit_s = ({1'b0, outstanding_nx} + {1'b0, fifo_nx_s}) < {1'b0, DEPTH_C};

    assign o_app_en      = app_en_r;
    assign o_app_cmd     = app_cmd_r;
    assign o_app_addr    = app_addr_r;
    assign o_rd_overflow = overflow_r;
    assign o_busy        = (state_r != ST_IDLE) | (outstanding_r != {FC_W{1'b0}})
                           | o_rdata_valid;

    // Outstanding-read tracking: issued read commands minus returned beats.
    always_comb begin
        outstanding_nx = outstanding_r;
        if (rd_hs_s && !ret_s) begin
            outstanding_nx = outstanding_r + {{(FC_W-1){1'b0}}, 1'b1};
        end else if (!rd_hs_s && ret_s) begin
            outstanding_nx = outstanding_r - {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
            outstanding_nx = outstanding_r;
        end
    end

    // Next-state and command-channel logic.
    always_comb begin
        state_nx    = state_r;
        len_nx      = len_r;
        cmd_cnt_nx  = cmd_cnt_r + {{(CNT_W-1){1'b0}}, cmd_hs_s};
        dat_cnt_nx  = dat_cnt_r + {{(CNT_W-1){1'b0}}, wdf_hs_s};
        app_en_nx   = app_en_r;
        app_cmd_nx  = app_cmd_r;
        app_addr_nx = cmd_hs_s ? (app_addr_r + STEP_C) : app_addr_r;
        case (state_r)
            ST_IDLE: begin
                app_en_nx = 1'b0;
                if (accept_s) begin
                    len_nx      = i_req_len;
                    cmd_cnt_nx  = {CNT_W{1'b0}};
                    dat_cnt_nx  = {CNT_W{1'b0}};
                    app_addr_nx = i_req_addr;
                    if (i_req_write) begin
                        state_nx   = ST_WRITE;
                        app_cmd_nx = CMD_WR;
                        app_en_nx  = 1'b1;
                    end else begin
                        state_nx   = ST_READ;
                        app_cmd_nx = CMD_RD;
                        app_en_nx  = credit_s;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WRITE: begin
                app_en_nx = (cmd_cnt_nx <= last_s);
                if ((cmd_cnt_nx == beats_s) && (dat_cnt_nx == beats_s)) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_WRITE;
                end
            end
            ST_READ: begin
                // An offered command is held until taken; a new one needs credit.
                app_en_nx = (app_en_r & ~i_app_rdy) | ((cmd_cnt_nx <= last_s) & credit_s);
                if (cmd_cnt_nx == beats_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_READ;
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                app_en_nx = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and registered app command outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            ready_en_r    <= 1'b0;
            len_r         <= {LEN_WIDTH{1'b0}};
            cmd_cnt_r     <= {CNT_W{1'b0}};
            dat_cnt_r     <= {CNT_W{1'b0}};
            app_en_r      <= 1'b0;
            app_cmd_r     <= CMD_WR;
            app_addr_r    <= {ADDR_WIDTH{1'b0}};
            outstanding_r <= {FC_W{1'b0}};
        end else begin
            state_r       <= state_nx;
            ready_en_r    <= 1'b1;
            len_r         <= len_nx;
            cmd_cnt_r     <= cmd_cnt_nx;
            dat_cnt_r     <= dat_cnt_nx;
            app_en_r      <= app_en_nx;
            app_cmd_r     <= app_cmd_nx;
            app_addr_r    <= app_addr_nx;
            outstanding_r <= outstanding_nx;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= {FC_W{1'b0}};
            rd_ptr_r   <= {FC_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + {{(FC_W-1){1'b0}}, push_s};
            rd_ptr_r   <= rd_ptr_r + {{(FC_W-1){1'b0}}, pop_s};
            overflow_r <= overflow_r | (i_app_rd_data_valid & fifo_full_s);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= i_app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr_app_sequencer.sv
module tb_ddr_app_sequencer;
    localparam int AW = 24;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calib = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_write = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [LW-1:0] i_req_len = '0;
    logic          i_wdata_valid = 1'b0;
    logic          o_wdata_ready;
    logic [DW-1:0] i_wdata = '0;
    logic [MW-1:0] i_wbe = '0;
    logic          o_rdata_valid;
    logic          i_rdata_ready = 1'b1;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_app_addr;
    logic [2:0]    o_app_cmd;
    logic          o_app_en;
    logic          i_app_rdy = 1'b1;
    logic [DW-1:0] o_app_wdf_data;
    logic [MW-1:0] o_app_wdf_mask;
    logic          o_app_wdf_wren;
    logic          o_app_wdf_end;
    logic          i_app_wdf_rdy = 1'b1;
    logic [DW-1:0] i_app_rd_data = '0;
    logic          i_app_rd_data_valid = 1'b0;
    logic          o_busy;
    logic          o_rd_overflow;

    ddr_app_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
        .ADDR_STEP(8), .LEN_WIDTH(LW), .RD_FIFO_DEPTH(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_init_calib_complete(calib),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
        .i_wdata(i_wdata), .i_wbe(i_wbe),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
        .o_app_addr(o_app_addr), .o_app_cmd(o_app_cmd), .o_app_en(o_app_en),
        .i_app_rdy(i_app_rdy),
        .o_app_wdf_data(o_app_wdf_data), .o_app_wdf_mask(o_app_wdf_mask),
        .o_app_wdf_wren(o_app_wdf_wren), .o_app_wdf_end(o_app_wdf_end),
        .i_app_wdf_rdy(i_app_wdf_rdy),
        .i_app_rd_data(i_app_rd_data), .i_app_rd_data_valid(i_app_rd_data_valid),
        .o_busy(o_busy), .o_rd_overflow(o_rd_overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard queues.
    logic [26:0]   exp_cmd_q[$];   // {cmd, addr}
    logic [143:0]  exp_wr_q[$];    // {data, mask}
    logic [127:0]  exp_rd_q[$];
    logic [AW-1:0] mig_addr_q[$];
    int            mig_due_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_hs_cnt = 0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rd_model(input logic [AW-1:0] a);
        return {4{8'hC3, a}};
    endfunction

    // Command-channel monitor: scoreboard, stall-hold check, MIG read capture.
    initial begin
        bit            stall_prev;
        logic [26:0]   prev_ca;
        stall_prev = 1'b0;
        prev_ca = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) check("cmd_hold", {o_app_en, o_app_cmd, o_app_addr}, {1'b1, prev_ca});
                stall_prev = o_app_en && !i_app_rdy;
                prev_ca = {o_app_cmd, o_app_addr};
                if (o_app_en && i_app_rdy) begin
                    if (exp_cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmd_unexpected: got %0h expected none", {o_app_cmd, o_app_addr});
                    end else begin
                        check("app_cmd_addr", {o_app_cmd, o_app_addr}, exp_cmd_q.pop_front());
                    end
                    if (o_app_cmd == 3'b001) begin
                        rd_hs_cnt++;
                        mig_addr_q.push_back(o_app_addr);
                        mig_due_q.push_back(cyc + 3);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Write-data and read-data monitors.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_app_wdf_wren && i_app_wdf_rdy) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wbeat_unexpected: got %0h expected none", o_app_wdf_data);
                end else begin
                    check("wdf_data_mask", {o_app_wdf_data, o_app_wdf_mask}, exp_wr_q.pop_front());
                end
                check("wdf_end", o_app_wdf_end, 1'b1);
            end
            if (rst_n && o_rdata_valid && i_rdata_ready) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rdata_unexpected: got %0h expected none", o_rdata);
                end else begin
                    check("rdata", o_rdata, exp_rd_q.pop_front());
                end
            end
        end
    end

    // MIG read-return model: one beat per cycle, three cycles after the command.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i_app_rd_data_valid = 1'b0;
            if (mig_addr_q.size() > 0 && mig_due_q[0] <= cyc) begin
                i_app_rd_data = rd_model(mig_addr_q.pop_front());
                void'(mig_due_q.pop_front());
                i_app_rd_data_valid = 1'b1;
            end
        end
    end

    task automatic send_req(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        logic [AW-1:0] a;
        bit ok;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_cmd_q.push_back({(wr ? 3'b000 : 3'b001), a});
            if (!wr) exp_rd_q.push_back(rd_model(a));
            a = a + 24'd8;
        end
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_len = len;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (o_req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        check("req_accept", ok, 1'b1);
    endtask

    task automatic send_wdata(input int n, input logic [31:0] seed, input logic [MW-1:0] be);
        bit ok;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = seed + 32'(i);
            i_wdata = {4{w}}; i_wbe = be; i_wdata_valid = 1'b1;
            exp_wr_q.push_back({{4{w}}, ~be});
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clk);
                if (o_wdata_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            check("wbeat_accept", ok, 1'b1);
        end
        i_wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 400 && !idle; k++) begin
            @(negedge clk);
            if (!o_busy) idle = 1'b1;
        end
        check("idle_reached", idle, 1'b1);
        @(posedge clk); #1;
    endtask

    // Holds app_wdf_rdy low until the first command shows, then app_rdy low 5 cycles.
    task automatic stall_ctrl();
        bit seen;
        seen = 1'b0;
        i_app_wdf_rdy = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (o_app_en && i_app_rdy) begin
                seen = 1'b1;
                check("wdf_stall_ready", o_wdata_ready, 1'b0);
                check("wdf_stall_wren", o_app_wdf_wren, 1'b1);
            end
        end
        check("stall_seen", seen, 1'b1);
        @(posedge clk); #1;
        i_app_rdy = 1'b0;
        i_app_wdf_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_app_rdy = 1'b1;
    endtask

    task automatic mask_probe();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (o_app_wdf_wren) begin
                seen = 1'b1;
                check("wdf_mask_00ff", o_app_wdf_mask, 16'hFF00);
            end
        end
        check("mask_seen", seen, 1'b1);
    endtask

    initial begin
        int base;
        // Reset values while held in reset (calibration already complete).
        repeat (3) @(posedge clk);
        #1;
        check("rst_app_en", o_app_en, 1'b0);
        check("rst_app_cmd", o_app_cmd, 3'b000);
        check("rst_app_addr", o_app_addr, 24'h0);
        check("rst_req_ready", o_req_ready, 1'b0);
        check("rst_rdata_valid", o_rdata_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overflow", o_rd_overflow, 1'b0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Calibration gates acceptance.
        calib = 1'b0;
        @(negedge clk); check("calib_low_ready", o_req_ready, 1'b0);
        @(posedge clk); #1 calib = 1'b1;
        @(negedge clk); check("calib_high_ready", o_req_ready, 1'b1);
        @(posedge clk); #1;

        // Single write, cycle-exact.
        exp_cmd_q.push_back({3'b000, 24'h000100});
        exp_wr_q.push_back({{16{8'hA5}}, 16'h0000});
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 24'h000100; i_req_len = 2'd0;
        i_wdata_valid = 1'b1; i_wdata = {16{8'hA5}}; i_wbe = 16'hFFFF;
        @(negedge clk); check("t1_accept", o_req_ready, 1'b1);
        @(posedge clk); #1 i_req_valid = 1'b0;
        @(negedge clk);
        check("t1_app_en", o_app_en, 1'b1);
        check("t1_wren", o_app_wdf_wren, 1'b1);
        @(posedge clk); #1 i_wdata_valid = 1'b0;
        @(negedge clk); check("t1_idle", {o_busy, o_req_ready, o_app_en}, 3'b010);
        @(posedge clk); #1;

        // 4-beat read wrapping the 24-bit address space.
        send_req(1'b0, 24'hFFFFF8, 2'd3);
        wait_idle();

        // 4-beat write with app_wdf_rdy and app_rdy stalls.
        fork
            send_req(1'b1, 24'h001000, 2'd3);
            send_wdata(4, 32'hD0D0_0000, 16'hFFFF);
            stall_ctrl();
        join
        wait_idle();

        // Credit limit: consumer stalled, three 4-beat reads.
        base = rd_hs_cnt;
        i_rdata_ready = 1'b0;
        send_req(1'b0, 24'h002000, 2'd3);
        send_req(1'b0, 24'h002100, 2'd3);
        send_req(1'b0, 24'h002200, 2'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("credit_cmds", rd_hs_cnt - base, 8);
        check("credit_app_en", o_app_en, 1'b0);
        check("credit_rdata_valid", o_rdata_valid, 1'b1);
        check("credit_overflow", o_rd_overflow, 1'b0);
        @(posedge clk); #1 i_rdata_ready = 1'b1;
        wait_idle();
        check("credit_total_cmds", rd_hs_cnt - base, 12);
        check("credit_overflow_end", o_rd_overflow, 1'b0);

        // Byte-enable inversion.
        fork
            send_req(1'b1, 24'h003000, 2'd0);
            send_wdata(1, 32'h1234_5678, 16'h00FF);
            mask_probe();
        join
        wait_idle();

        // Asynchronous reset in the middle of a 4-beat write.
        for (int i = 0; i < 4; i++) begin
            exp_cmd_q.push_back({3'b000, 24'h004000 + 24'(8 * i)});
            exp_wr_q.push_back({{4{32'hBEEF_0001}}, 16'h0000});
        end
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 24'h004000; i_req_len = 2'd3;
        i_wdata_valid = 1'b1; i_wdata = {4{32'hBEEF_0001}}; i_wbe = 16'hFFFF;
        @(negedge clk); check("t6_accept", o_req_ready, 1'b1);
        @(posedge clk); #1 i_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_app_en", o_app_en, 1'b0);
        check("t6_app_cmd", o_app_cmd, 3'b000);
        check("t6_app_addr", o_app_addr, 24'h0);
        check("t6_req_ready", o_req_ready, 1'b0);
        check("t6_busy", o_busy, 1'b0);
        check("t6_wren", o_app_wdf_wren, 1'b0);
        check("t6_wdata_ready", o_wdata_ready, 1'b0);
        check("t6_rdata_valid", o_rdata_valid, 1'b0);
        check("t6_cmds_issued", 4 - exp_cmd_q.size(), 2);
        exp_cmd_q.delete();
        exp_wr_q.delete();
        i_wdata_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_req(1'b0, 24'h005000, 2'd0);
        wait_idle();

        // Everything expected was observed.
        check("end_cmd_q", exp_cmd_q.size(), 0);
        check("end_wr_q", exp_wr_q.size(), 0);
        check("end_rd_q", exp_rd_q.size(), 0);
        check("end_mig_q", mig_addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
